// File: rtl/parking_session_ctrl.sv
// parking_session_ctrl: session sequencer for one parking bay.
// Flow: IDLE -> PARKED (counting) -> BILLING (frozen bill) -> GATE (timed gate pulse) -> IDLE.
// A payment timeout in BILLING returns to PARKED, and counting resumes from the frozen value.
// Optional build macro FREE_GRACE_EN: an exit below GRACE counts skips BILLING and opens the gate directly.
module parking_session_ctrl #(
    parameter int CNT_W     = 21,
    parameter int MAX_COUNT = 7799,
    parameter int GATE_HOLD = 50,
    parameter int PAY_TMO   = 1000,
    parameter int GRACE     = 600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             car_in,
    input  logic             car_out,
    input  logic             pay_ok,
    output logic [CNT_W-1:0] counterp,
    output logic             count_en,
    output logic             bill_valid,
    output logic             gate_open,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PARKED  = 2'd1,
        BILLING = 2'd2,
        GATE    = 2'd3
    } state_t;

    localparam int HOLD_W = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;
    localparam int TMO_W  = (PAY_TMO > 1) ? $clog2(PAY_TMO) : 1;

`ifdef FREE_GRACE_EN
    localparam bit FREE_EN = 1'b1;
`else
    localparam bit FREE_EN = 1'b0;
`endif

    state_t            state;
    logic              car_in_prev;
    logic              car_out_prev;
    logic              car_in_edge;
    logic              car_out_edge;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  count_inc;
    logic              grace_exit;

    assign car_in_edge  = car_in & ~car_in_prev;
    assign car_out_edge = car_out & ~car_out_prev;
    assign state_o      = state;

    // Short stays may leave for free; folds to 0 when the grace feature is not built in.
    assign grace_exit = FREE_EN && (counterp < CNT_W'(GRACE));

    // Next elapsed count, saturating at the last billable value instead of wrapping.
    always_comb begin
        count_inc = counterp;
        if (counterp != CNT_W'(MAX_COUNT)) begin
            count_inc = counterp + CNT_W'(1);
        end
    end

    // Previous sensor levels for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_in_prev  <= 1'b0;
            car_out_prev <= 1'b0;
        end else begin
            car_in_prev  <= car_in;
            car_out_prev <= car_out;
        end
    end

    // Session FSM; outputs are registered and change together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counterp   <= '0;
            count_en   <= 1'b0;
            bill_valid <= 1'b0;
            gate_open  <= 1'b0;
            hold_cnt   <= '0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // car_in wins over a simultaneous car_out, which is simply dropped
                    if (car_in_edge) begin
                        state    <= PARKED;
                        counterp <= '0;
                        count_en <= 1'b1;
                    end
                end
                PARKED: begin
                    // a tick coinciding with the exit request is still counted
                    if (tick) begin
                        counterp <= count_inc;
                    end
                    if (car_out_edge) begin
                        count_en <= 1'b0;
                        if (grace_exit) begin
                            state     <= GATE;
                            gate_open <= 1'b1;
                            hold_cnt  <= HOLD_W'(GATE_HOLD - 1);
                        end else begin
                            state      <= BILLING;
                            bill_valid <= 1'b1;
                            tmo_cnt    <= '0;
                        end
                    end
                end
                BILLING: begin
                    // payment takes priority over a timeout landing in the same cycle
                    if (pay_ok) begin
                        state      <= GATE;
                        bill_valid <= 1'b0;
                        gate_open  <= 1'b1;
                        hold_cnt   <= HOLD_W'(GATE_HOLD - 1);
                    end else if (tick) begin
                        if (tmo_cnt == TMO_W'(PAY_TMO - 1)) begin
                            state      <= PARKED;
                            bill_valid <= 1'b0;
                            count_en   <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                end
                GATE: begin
                    // hold_cnt runs GATE_HOLD-1 down to 0, giving GATE_HOLD cycles of gate_open
                    if (hold_cnt == '0) begin
                        state     <= IDLE;
                        gate_open <= 1'b0;
                        counterp  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
